csp_rr_merge: RTL and testbench

Clocked round-robin merge controller that shares one 4-phase CSP output channel among N input channels in the router. Each input presents a request and data word. The block grants one requester at a time, forwards its word on the shared output channel, and completes both handshakes before granting again. It sits between the per-port input buffers and a single downstream buffer or bit sink. Fairness is rotating priority.

---
 rtl/csp_rr_merge_pkg.sv | 22 ++
 rtl/csp_rr_merge_if.sv | 26 ++
 rtl/csp_rr_merge_pick.sv | 33 +++
 rtl/csp_rr_merge.sv | 100 ++++++++++
 tb/tb_csp_rr_merge.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csp_rr_merge_pkg.sv
// Shared types and helpers for the round-robin CSP merge controller.
package csp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OUT_REQ = 2'd1,
    ST_OUT_RTZ = 2'd2,
    ST_IN_ACK  = 2'd3
  } arb_state_t;

  // Widest index the helper handles (N_IN up to 8).
  localparam int unsigned PTR_W = 3;

  // Round-robin successor of g among n inputs, wrapping explicitly at n.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g,
                                                input int unsigned       n);
    logic [PTR_W:0] inc;
    inc = {1'b0, g} + (PTR_W+1)'(1);
    return (32'(inc) >= n) ? '0 : inc[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/csp_rr_merge_if.sv
// Bundle of the N input channels and the shared output channel of the merge.
interface csp_rr_merge_if #(
  parameter int unsigned N_IN = 4,
  parameter int unsigned W    = 1
);
  localparam int unsigned GW = $clog2(N_IN);

  logic [N_IN-1:0]   in_req;
  logic [N_IN*W-1:0] in_data;
  logic [N_IN-1:0]   in_ack;
  logic              out_req;
  logic [W-1:0]      out_data;
  logic              out_ack;
  logic [GW-1:0]     grant;
  logic              busy;

  // slave: the merge block itself; master: the surrounding senders and sink.
  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, grant, busy
  );
  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, grant, busy
  );
endinterface

// File: rtl/csp_rr_merge_pick.sv
// Combinational round-robin picker: rotate by ptr, priority encode, rotate back.
module rr_pick #(
  parameter int unsigned N_IN = 4
) (
  input  logic [N_IN-1:0]         req,
  input  logic [$clog2(N_IN)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(N_IN)-1:0] idx
);
  localparam int unsigned GW = $clog2(N_IN);

  logic [2*N_IN-1:0] dbl;
  logic [N_IN-1:0]   rot;
  logic [GW-1:0]     off;
  logic [GW:0]       sum;

  always_comb begin
    dbl   = {req, req};
    rot   = N_IN'(dbl >> ptr);
    off   = '0;
    valid = 1'b0;
    // Scan high to low so the lowest rotated position (closest to ptr) wins.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = GW'(i);
        valid = 1'b1;
      end
    end
    sum = (GW+1)'(ptr) + (GW+1)'(off);
    idx = (sum >= (GW+1)'(N_IN)) ? GW'(sum - (GW+1)'(N_IN)) : GW'(sum);
  end

endmodule

// File: rtl/csp_rr_merge.sv
// Round-robin merge of N_IN 4-phase CSP input channels onto one shared output channel.
module csp_rr_merge
  import csp_arb_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned W    = 1
) (
  input logic           clk,
  input logic           reset,
  csp_rr_merge_if.slave ch
);
  localparam int unsigned GW = $clog2(N_IN);

  arb_state_t      state, state_d;
  logic [GW-1:0]   grant, grant_d;
  logic [GW-1:0]   ptr, ptr_d;
  logic            out_req, out_req_d;
  logic [W-1:0]    out_data, out_data_d;
  logic [N_IN-1:0] in_ack, in_ack_d;
  logic            busy, busy_d;
  logic            pick_valid;
  logic [GW-1:0]   pick_idx;

  rr_pick #(.N_IN(N_IN)) u_pick (
    .req   (ch.in_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // All outputs and the pointer are registered; the reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ptr      <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      in_ack   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      ptr      <= ptr_d;
      out_req  <= out_req_d;
      out_data <= out_data_d;
      in_ack   <= in_ack_d;
      busy     <= busy_d;
    end
  end

  // The input ack is only raised once the output handshake has returned to zero.
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    ptr_d      = ptr;
    out_req_d  = out_req;
    out_data_d = out_data;
    in_ack_d   = in_ack;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          out_data_d = ch.in_data[pick_idx*W +: W];
          out_req_d  = 1'b1;
          state_d    = ST_OUT_REQ;
        end
      end
      ST_OUT_REQ: begin
        if (ch.out_ack) begin
          out_req_d = 1'b0;
          state_d   = ST_OUT_RTZ;
        end
      end
      ST_OUT_RTZ: begin
        if (!ch.out_ack) begin
          in_ack_d        = '0;
          in_ack_d[grant] = 1'b1;
          state_d         = ST_IN_ACK;
        end
      end
      ST_IN_ACK: begin
        if (!ch.in_req[grant]) begin
          in_ack_d = '0;
          ptr_d    = GW'(next_ptr(PTR_W'(grant), N_IN));
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign ch.grant    = grant;
  assign ch.out_req  = out_req;
  assign ch.out_data = out_data;
  assign ch.in_ack   = in_ack;
  assign ch.busy     = busy;

endmodule

// File: tb/tb_csp_rr_merge.sv
// Scoreboard bench for csp_rr_merge with zero-wait 4-phase senders and a stallable sink.
module tb_csp_rr_merge;
  import csp_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 1;
  localparam int          TO = 200;

  typedef struct {
    int           g;
    logic [W-1:0] d;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] raise;
  logic [N-1:0] pend;
  logic [N-1:0] data;
  logic         sink_ready;
  int           cyc;
  int           tests;
  int           fails;
  exp_t         sb[$];

  csp_rr_merge_if #(.N_IN(N), .W(W)) bus ();

  csp_rr_merge #(.N_IN(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ch    (bus)
  );

  // Senders hold request until acked; the sink acks as soon as it is ready.
  assign bus.in_req  = pend & ~bus.in_ack;
  assign bus.in_data = data;
  assign bus.out_ack = bus.out_req & sink_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= (pend | raise) & ~bus.in_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset      = 1'b0;
    raise      = '0;
    data       = '0;
    sink_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic send(input logic [N-1:0] m);
    @(negedge clk) raise = m;
    @(negedge clk) raise = '0;
  endtask

  // Observe the next rising edge of out_req; ok=0 on timeout.
  task automatic wait_xfer(output bit ok, output int c, output int g, output logic [W-1:0] d);
    int n;
    n  = 0;
    ok = 1'b0;
    while (bus.out_req === 1'b1 && n < TO) begin
      @(posedge clk); #1; n++;
    end
    while (n < TO) begin
      @(posedge clk); #1; n++;
      if (bus.out_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    c = cyc;
    g = int'(bus.grant);
    d = bus.out_data;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || pend !== '0) && n < TO) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n >= TO) begin
      fails++;
      $display("FAIL %s_drain: busy=%b pend=%b after %0d cycles, required idle", name, bus.busy, pend, n);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    raise      = '0;
    data       = '0;
    sink_ready = 1'b1;
    #1;
    tests++;
    if ({bus.out_req, bus.out_data, bus.in_ack, bus.grant, bus.busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b data=%b ack=%b grant=%0d busy=%b, required all 0",
               bus.out_req, bus.out_data, bus.in_ack, bus.grant, bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (dut.state !== ST_IDLE || dut.ptr !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: state=%0d ptr=%0d busy=%b, required 0/0/0", dut.state, dut.ptr, bus.busy);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    data = 4'b0100;
    sb.push_back('{2, 1'b1});
    @(negedge clk) raise = 4'b0100;
    @(posedge clk); #1;
    tests++;
    if (bus.in_req !== 4'b0100 || bus.out_req !== 1'b0) begin
      fails++;
      $display("FAIL single_req_seen: in_req=%b out_req=%b, required 0100/0", bus.in_req, bus.out_req);
    end
    @(negedge clk) raise = '0;
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (bus.out_req !== 1'b1 || int'(bus.grant) != e.g || bus.out_data !== e.d || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: out_req=%b grant=%0d data=%b busy=%b, required 1/%0d/%b/1",
               bus.out_req, bus.grant, bus.out_data, bus.busy, e.g, e.d);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.out_req !== 1'b0 || bus.in_ack !== 4'b0000) begin
      fails++;
      $display("FAIL single_rtz: out_req=%b in_ack=%b, required 0/0000", bus.out_req, bus.in_ack);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.in_ack !== 4'b0100 || bus.out_ack !== 1'b0) begin
      fails++;
      $display("FAIL single_in_ack: in_ack=%b out_ack=%b, required 0100/0", bus.in_ack, bus.out_ack);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.in_ack !== 4'b0000 || bus.busy !== 1'b0 || dut.ptr !== 2'd3) begin
      fails++;
      $display("FAIL single_done: in_ack=%b busy=%b ptr=%0d, required 0000/0/3", bus.in_ack, bus.busy, dut.ptr);
    end
  endtask

  task automatic test_all_four();
    exp_t         e;
    bit           ok;
    int           c, g, prev;
    logic [W-1:0] d;
    do_reset();
    data = 4'b0110;
    for (int i = 0; i < 4; i++) sb.push_back('{i, data[i]});
    send(4'b1111);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_xfer(ok, c, g, d);
      e = sb.pop_front();
      tests++;
      if (!ok || g != e.g || d !== e.d) begin
        fails++;
        $display("FAIL all4_order[%0d]: ok=%b grant=%0d data=%b, required grant=%0d data=%b", i, ok, g, d, e.g, e.d);
      end
      if (i > 0) begin
        tests++;
        if (c - prev != 4) begin
          fails++;
          $display("FAIL all4_period[%0d]: %0d cycles between grants, required 4", i, c - prev);
        end
      end
      prev = c;
    end
    drain("all4");
  endtask

  task automatic test_rotation();
    exp_t         e;
    bit           ok;
    int           c, g;
    logic [W-1:0] d;
    do_reset();
    data = 4'b1010;
    sb.push_back('{2, 1'b0});
    sb.push_back('{3, 1'b1});
    sb.push_back('{1, 1'b1});
    send(4'b0100);
    wait_xfer(ok, c, g, d);
    e = sb.pop_front();
    tests++;
    if (!ok || g != e.g || d !== e.d) begin
      fails++;
      $display("FAIL rot_first: ok=%b grant=%0d data=%b, required %0d/%b", ok, g, d, e.g, e.d);
    end
    drain("rot_first");
    send(4'b1010);
    for (int i = 0; i < 2; i++) begin
      wait_xfer(ok, c, g, d);
      e = sb.pop_front();
      tests++;
      if (!ok || g != e.g || d !== e.d) begin
        fails++;
        $display("FAIL rot_order[%0d]: ok=%b grant=%0d data=%b, required %0d/%b", i, ok, g, d, e.g, e.d);
      end
    end
    drain("rot_pair");
  endtask

  task automatic test_stall();
    exp_t         e;
    bit           ok, bad;
    int           c, g;
    logic [W-1:0] d;
    do_reset();
    sink_ready = 1'b0;
    data = 4'b0001;
    sb.push_back('{0, 1'b1});
    send(4'b0001);
    wait_xfer(ok, c, g, d);
    e = sb.pop_front();
    tests++;
    if (!ok || g != e.g || d !== e.d) begin
      fails++;
      $display("FAIL stall_grant: ok=%b grant=%0d data=%b, required %0d/%b", ok, g, d, e.g, e.d);
    end
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_req !== 1'b1 || bus.out_data !== e.d || bus.in_ack !== '0 || dut.state !== ST_OUT_REQ)
        bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL stall_hold: out_req=%b data=%b in_ack=%b state=%0d, required 1/%b/0000/1 throughout",
               bus.out_req, bus.out_data, bus.in_ack, dut.state, e.d);
    end
    @(negedge clk) sink_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_data_change();
    exp_t         e;
    bit           ok, bad;
    int           c, g;
    logic [W-1:0] d;
    do_reset();
    sink_ready = 1'b0;
    data = 4'b0010;
    sb.push_back('{1, 1'b1});
    send(4'b0010);
    wait_xfer(ok, c, g, d);
    e = sb.pop_front();
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk) data[1] = ~data[1];
      @(posedge clk); #1;
      if (bus.out_data !== e.d) bad = 1'b1;
    end
    tests++;
    if (!ok || g != e.g || bad) begin
      fails++;
      $display("FAIL data_latched: ok=%b grant=%0d data=%b, required %0d/%b held", ok, g, bus.out_data, e.g, e.d);
    end
    @(negedge clk) sink_ready = 1'b1;
    drain("data_change");
  endtask

  task automatic test_reset_mid();
    exp_t         e;
    bit           ok;
    int           c, g;
    logic [W-1:0] d;
    do_reset();
    data = 4'b1100;
    send(4'b0100);
    wait_xfer(ok, c, g, d);
    @(posedge clk); #1;
    tests++;
    if (!ok || g != 2 || dut.state !== ST_OUT_RTZ || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_rtz: ok=%b grant=%0d state=%0d busy=%b, required 1/2/2/1", ok, g, dut.state, bus.busy);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.out_req, bus.out_data, bus.in_ack, bus.grant, bus.busy} !== '0 || dut.state !== ST_IDLE) begin
      fails++;
      $display("FAIL rmid_async: req=%b data=%b ack=%b grant=%0d busy=%b state=%0d, required all 0",
               bus.out_req, bus.out_data, bus.in_ack, bus.grant, bus.busy, dut.state);
    end
    @(negedge clk) reset = 1'b1;
    #1;
    tests++;
    if (dut.ptr !== '0) begin
      fails++;
      $display("FAIL rmid_ptr: ptr=%0d, required 0", dut.ptr);
    end
    sb.push_back('{3, 1'b1});
    send(4'b1000);
    wait_xfer(ok, c, g, d);
    e = sb.pop_front();
    tests++;
    if (!ok || g != e.g || d !== e.d) begin
      fails++;
      $display("FAIL rmid_after: ok=%b grant=%0d data=%b, required %0d/%b", ok, g, d, e.g, e.d);
    end
    drain("rmid");
    tests++;
    if (dut.ptr !== '0 || bus.in_ack !== '0) begin
      fails++;
      $display("FAIL rmid_wrap: ptr=%0d in_ack=%b, required 0/0000", dut.ptr, bus.in_ack);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_stall();
    test_data_change();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
